// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit feeder slice.
//   UART_BYTE_W         width of one UART payload byte
//   TX_TIMEOUT_DEFAULT  default number of cycles the transmitter is given to
//                       acknowledge a send request
//   drain_state_t       states of the drain controller in uart_tx_feeder
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W        = 8;
    localparam int TX_TIMEOUT_DEFAULT = 32;

    typedef enum logic [1:0] {
        DRAIN_IDLE      = 2'd0,
        DRAIN_REQ       = 2'd1,
        DRAIN_WAIT_BUSY = 2'd2,
        DRAIN_WAIT_IDLE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Byte FIFO feeding the drain controller. The head byte is always visible on
// rd_data; asserting rd_en consumes it.
// Ports:
//   clock, reset_n  system clock, synchronous active-low reset
//   wr_en, wr_data  push request and byte (dropped when full)
//   rd_en           pop the head byte (ignored when empty)
//   rd_data         current head byte
//   full, empty     occupancy flags decoded from level
//   level           occupancy 0..DEPTH
//   overflow        sticky flag: push attempted while full
// ---------------------------------------------------------------------------
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   overflow
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [UART_BYTE_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic                   push;
    logic                   pop;

    // Fullness is judged on the registered level, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    assign rd_data  = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

    // Next-state for storage, pointers, occupancy and the overflow flag.
    // Pointers are ADDR_W wide and DEPTH is a power of two, so they wrap
    // naturally.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q || (wr_en && full);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (ADDR_W + 1)'(1);
        end
    end

    // Control state; reset empties the FIFO and clears the overflow flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte FIFO plus drain controller sitting in front of the UART transmitter.
// Bytes are offered one at a time over the uart_send / uart_done handshake;
// uart_data stays stable from the pop until the controller is idle again,
// and a transmitter that never acknowledges raises a sticky tx_timeout.
// Ports:
//   clock, reset_n   system clock, synchronous active-low reset
//   wr_en, wr_data   push request and byte from host logic
//   full, empty      FIFO occupancy flags
//   level            FIFO occupancy 0..DEPTH
//   overflow         sticky: push attempted while full
//   tx_timeout       sticky: transmitter failed to acknowledge a request
//   uart_send        request to the transmitter
//   uart_data        byte offered to the transmitter
//   uart_done        transmitter idle (1) / busy (0)
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = TX_TIMEOUT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic                   overflow,
    output logic                   tx_timeout,
    output logic                   uart_send,
    output logic [UART_BYTE_W-1:0] uart_data,
    input  logic                   uart_done
);

    localparam int              TIMER_W    = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    drain_state_t           state_q, state_d;
    logic                   uart_send_q, uart_send_d;
    logic [UART_BYTE_W-1:0] uart_data_q, uart_data_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   tx_timeout_q, tx_timeout_d;
    logic [UART_BYTE_W-1:0] head_data;
    logic                   pop;

    // A byte is popped only from IDLE with the transmitter ready.
    assign pop = (state_q == DRAIN_IDLE) && !empty && uart_done;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    assign uart_send  = uart_send_q;
    assign uart_data  = uart_data_q;
    assign tx_timeout = tx_timeout_q;

    // Drain controller next-state. uart_data only changes on a pop, which
    // keeps it stable for the whole frame. A timed-out byte is dropped and
    // WAIT_IDLE still waits for the transmitter to report idle.
    always_comb begin
        state_d      = state_q;
        uart_send_d  = uart_send_q;
        uart_data_d  = uart_data_q;
        timer_d      = timer_q;
        tx_timeout_d = tx_timeout_q;
        case (state_q)
            DRAIN_IDLE: begin
                if (pop) begin
                    uart_data_d = head_data;
                    uart_send_d = 1'b1;
                    timer_d     = '0;
                    state_d     = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                if (!uart_done) begin
                    uart_send_d = 1'b0;
                    state_d     = DRAIN_WAIT_BUSY;
                end else if (timer_q == TIMER_LAST) begin
                    uart_send_d  = 1'b0;
                    tx_timeout_d = 1'b1;
                    state_d      = DRAIN_WAIT_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            DRAIN_WAIT_BUSY: begin
                state_d = DRAIN_WAIT_IDLE;
            end
            DRAIN_WAIT_IDLE: begin
                if (uart_done) begin
                    state_d = DRAIN_IDLE;
                end
            end
            default: begin
                state_d = DRAIN_IDLE;
            end
        endcase
    end

    // Registered FSM state and outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= DRAIN_IDLE;
            uart_send_q  <= 1'b0;
            uart_data_q  <= '0;
            timer_q      <= '0;
            tx_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            uart_send_q  <= uart_send_d;
            uart_data_q  <= uart_data_d;
            timer_q      <= timer_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

endmodule
